// File: rtl/cla5_manchester.sv
// rtl/cla5_manchester.sv - 5-bit carry-lookahead adder with a static Manchester carry chain
//
// Purpose:
//   Unsigned 5-bit adder. Per-bit generate/propagate/kill signals steer a
//   static Manchester carry chain. Sum and carry outputs are combinational.
//   A registered copy of the result is provided for pipelined datapaths.
//   Group generate/propagate outputs allow cascading into wider adders.
//
// Ports:
//   clk    in   1  clock for the registered result copy
//   rst    in   1  asynchronous active-high reset, clears S_r/Cout_r only
//   A      in   5  operand A
//   B      in   5  operand B
//   Cin    in   1  carry into bit 0
//   S      out  5  combinational sum, A+B+Cin mod 32
//   Cout   out  1  combinational carry out of bit 4
//   Pg     out  1  group propagate, AND of all per-bit propagates
//   Gg     out  1  group generate, carry out of bit 4 with Cin forced to 0
//   S_r    out  5  S registered on rising clk
//   Cout_r out  1  Cout registered on rising clk

module cla5_manchester (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Cin,
    output logic [4:0] S,
    output logic       Cout,
    output logic       Pg,
    output logic       Gg,
    output logic [4:0] S_r,
    output logic       Cout_r
);

    logic [4:0] p;
    logic [4:0] g;
    logic [4:0] k;
    logic [5:0] c;
    logic [5:0] cz;

    assign p = A ^ B;
    assign g = A & B;
    assign k = ~A & ~B;

    // Each stage either generates a carry, kills it, or passes the incoming
    // carry through. Exactly one of g/k/p is set per bit, so the mux below
    // is a plain static pass/generate/kill switch.
    // The cz chain runs the same stages with a zero carry-in to give Gg.
    always_comb begin
        c     = '0;
        cz    = '0;
        c[0]  = Cin;
        cz[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (g[i]) begin
                c[i+1]  = 1'b1;
                cz[i+1] = 1'b1;
            end else if (k[i]) begin
                c[i+1]  = 1'b0;
                cz[i+1] = 1'b0;
            end else begin
                c[i+1]  = c[i];
                cz[i+1] = cz[i];
            end
        end
    end

    assign S    = p ^ c[4:0];
    assign Cout = c[5];
    assign Pg   = &p;
    assign Gg   = cz[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_r    <= '0;
            Cout_r <= 1'b0;
        end else begin
            S_r    <= S;
            Cout_r <= Cout;
        end
    end

endmodule

// File: tb/tb_cla5_manchester.sv
// tb/tb_cla5_manchester.sv - self-checking bench for cla5_manchester

module tb_cla5_manchester;

    logic       clk;
    logic       rst;
    logic [4:0] A;
    logic [4:0] B;
    logic       Cin;
    logic [4:0] S;
    logic       Cout;
    logic       Pg;
    logic       Gg;
    logic [4:0] S_r;
    logic       Cout_r;

    int errors;
    int checks;

    cla5_manchester dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .S      (S),
        .Cout   (Cout),
        .Pg     (Pg),
        .Gg     (Gg),
        .S_r    (S_r),
        .Cout_r (Cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic       cin;
        logic [4:0] exp_s;
        logic       exp_cout;
        logic       exp_pg;
        logic       exp_gg;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (A=%0d B=%0d Cin=%0d)", name, act, exp, A, B, Cin);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input int a, input int b, input int cin,
                         output int m_s, output int m_cout, output int m_pg, output int m_gg);
        int sum;
        sum    = a + b + cin;
        m_s    = sum % 32;
        m_cout = (sum >= 32) ? 1 : 0;
        m_pg   = ((a ^ b) == 31) ? 1 : 0;
        m_gg   = ((a + b) >= 32) ? 1 : 0;
    endtask

    // Drive on the falling edge, check combinational outputs, then check the
    // registered copy just after the next rising edge.
    task automatic apply_model(input int a, input int b, input int cin, input string tag);
        int ms, mc, mp, mg;
        model(a, b, cin, ms, mc, mp, mg);
        @(negedge clk);
        A = 5'(a); B = 5'(b); Cin = 1'(cin);
        #1;
        chk({tag, "_S"}, int'(S), ms);
        chk({tag, "_Cout"}, int'(Cout), mc);
        chk({tag, "_Pg"}, int'(Pg), mp);
        chk({tag, "_Gg"}, int'(Gg), mg);
        chk({tag, "_inv"}, int'(Cout), int'(Gg | (Pg & Cin)));
        @(posedge clk);
        #1;
        chk({tag, "_S_r"}, int'(S_r), ms);
        chk({tag, "_Cout_r"}, int'(Cout_r), mc);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{5'b00011, 5'b00101, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5'b11111, 5'b00111, 1'b0, 5'b00110, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{5'b01010, 5'b01110, 1'b0, 5'b11000, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{5'b11100, 5'b11100, 1'b1, 5'b11001, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{5'b10101, 5'b01010, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{5'b10101, 5'b01010, 1'b0, 5'b11111, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{5'b11111, 5'b11111, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0};

        // Reset state: registers held at zero, combinational path live.
        rst = 1'b1;
        A = 5'b00011; B = 5'b00101; Cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_S_r", int'(S_r), 0);
        chk("reset_Cout_r", int'(Cout_r), 0);
        chk("reset_S_comb", int'(S), 8);

        // Release away from an edge; the first rising edge captures the sum.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_S_r", int'(S_r), 8);
        chk("release_Cout_r", int'(Cout_r), 0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            A = vecs[i].a; B = vecs[i].b; Cin = vecs[i].cin;
            #1;
            chk($sformatf("vec%0d_S", i), int'(S), int'(vecs[i].exp_s));
            chk($sformatf("vec%0d_Cout", i), int'(Cout), int'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_Pg", i), int'(Pg), int'(vecs[i].exp_pg));
            chk($sformatf("vec%0d_Gg", i), int'(Gg), int'(vecs[i].exp_gg));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_S_r", i), int'(S_r), int'(vecs[i].exp_s));
            chk($sformatf("vec%0d_Cout_r", i), int'(Cout_r), int'(vecs[i].exp_cout));
        end

        // Mid-cycle reset: registers clear at once, sum unaffected.
        @(negedge clk);
        A = 5'b11100; B = 5'b11100; Cin = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_pre_S_r", int'(S_r), 25);
        chk("midrst_pre_Cout_r", int'(Cout_r), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_S_r", int'(S_r), 0);
        chk("midrst_Cout_r", int'(Cout_r), 0);
        chk("midrst_S", int'(S), 25);
        chk("midrst_Cout", int'(Cout), 1);
        @(posedge clk);
        #1;
        chk("midrst_hold_S_r", int'(S_r), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_release_S_r", int'(S_r), 25);
        chk("midrst_release_Cout_r", int'(Cout_r), 1);

        // Randomized vectors against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            apply_model(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                        int'($urandom_range(0, 1)), "rand");
        end

        // Exhaustive sweep of all operand/carry combinations.
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    apply_model(a, b, ci, "sweep");
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
